// File: rtl/ddr_cmd_exec.sv
// ---------------------------------------------------------------------------
// ddr_cmd_exec
//
// Drains a first-word-fall-through command FIFO and turns its entries into
// memory-controller app_* transactions.
//   WT entry : issue one write command, then stream burst+1 WT entries as
//              write beats (the head entry's data/mask go straight out).
//   RD entry : issue one read command, popping the entry on acceptance,
//              then forward burst+1 returned read beats (registered).
//   IDE/CMD  : discarded, one per cycle.
//
// Ports
//   clk, rstn                  : clock, asynchronous active-low reset
//   io_pop_*                   : FIFO head entry (io_pop_ready = head valid),
//                                io_pop_valid = this block takes the head
//   app_cmd/_en/addr/burst_num : command request, app_cmd_rdy accepts it
//   app_wdf_*                  : write beat channel, app_wdf_rdy accepts it
//   app_rd_data/_valid         : read return, cannot be stalled
//   rd_valid/rd_data/rd_last   : registered read return to the user
//   busy                       : FSM not in IDLE
//   err                        : sticky protocol error
// ---------------------------------------------------------------------------
module ddr_cmd_exec #(
    parameter int ADDR_WIDTH = 27,
    parameter int BRST_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic                  io_pop_valid,
    input  logic                  io_pop_ready,
    input  logic [1:0]            io_pop_cmd_type,
    input  logic [ADDR_WIDTH-1:0] io_pop_addr,
    input  logic [BRST_WIDTH-1:0] io_pop_burst_cnt,
    input  logic [DATA_WIDTH-1:0] io_pop_wt_data,
    input  logic [MASK_WIDTH-1:0] io_pop_wt_mask,
    output logic [2:0]            app_cmd,
    output logic                  app_cmd_en,
    output logic [ADDR_WIDTH-1:0] app_addr,
    output logic [BRST_WIDTH-1:0] app_burst_number,
    input  logic                  app_cmd_rdy,
    output logic                  app_wdf_wren,
    output logic [DATA_WIDTH-1:0] app_wdf_data,
    output logic [MASK_WIDTH-1:0] app_wdf_mask,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0] app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  err
);

    localparam int CNT_WIDTH = BRST_WIDTH + 1;

    localparam logic [1:0] TYPE_IDE = 2'd0;
    localparam logic [1:0] TYPE_CMD = 2'd1;
    localparam logic [1:0] TYPE_WT  = 2'd2;
    localparam logic [1:0] TYPE_RD  = 2'd3;

    localparam logic [2:0] APP_CMD_WRITE = 3'd0;
    localparam logic [2:0] APP_CMD_READ  = 3'd1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WT_CMD  = 3'd1,
        WT_DATA = 3'd2,
        RD_CMD  = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [BRST_WIDTH-1:0] burst_reg;
    logic [CNT_WIDTH-1:0]  beat_cnt_reg;
    logic [CNT_WIDTH-1:0]  rd_cnt_reg;
    logic                  rd_valid_reg;
    logic                  rd_last_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  err_reg;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] burst_ext;
    logic                 head_is_wt;
    logic                 head_is_rd;
    logic                 idle_take_wt;
    logic                 idle_take_rd;
    logic                 wt_last;
    logic                 wt_abort;
    logic                 wt_accept;
    logic                 rd_cmd_accept;
    logic                 rd_beat;
    logic                 rd_last_beat;
    logic                 stray_rd;

    // Counters are one bit wider than the burst field so that burst=63
    // (64 beats) compares without wrapping.
    assign burst_ext     = {1'b0, burst_reg};
    assign head_is_wt    = (io_pop_cmd_type == TYPE_WT);
    assign head_is_rd    = (io_pop_cmd_type == TYPE_RD);
    assign idle_take_wt  = (state_reg == IDLE) && io_pop_ready && head_is_wt;
    assign idle_take_rd  = (state_reg == IDLE) && io_pop_ready && head_is_rd;
    assign wt_last       = (beat_cnt_reg == burst_ext);
    // A non-WT entry at the head mid-burst means the FIFO content is out of
    // step with the burst length: abandon the burst and leave the entry.
    assign wt_abort      = (state_reg == WT_DATA) && io_pop_ready && !head_is_wt;
    assign wt_accept     = (state_reg == WT_DATA) && io_pop_ready && head_is_wt
                           && app_wdf_rdy;
    assign rd_cmd_accept = (state_reg == RD_CMD) && app_cmd_rdy;
    assign rd_beat       = (state_reg == RD_WAIT) && app_rd_data_valid;
    assign rd_last_beat  = (rd_cnt_reg == burst_ext);
    assign stray_rd      = (state_reg != RD_WAIT) && app_rd_data_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (idle_take_wt) begin
                    state_next = WT_CMD;
                end else if (idle_take_rd) begin
                    state_next = RD_CMD;
                end
            end
            WT_CMD: begin
                if (app_cmd_rdy) begin
                    state_next = WT_DATA;
                end
            end
            WT_DATA: begin
                if (wt_abort) begin
                    state_next = IDLE;
                end else if (wt_accept && wt_last) begin
                    state_next = IDLE;
                end
            end
            RD_CMD: begin
                if (app_cmd_rdy) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_beat && rd_last_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Everything is gated by rstn so that a reset pulse
    // silences pops and strobes at once, even though IDLE would otherwise
    // discard an IDE/CMD head combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        io_pop_valid = 1'b0;
        app_cmd      = APP_CMD_WRITE;
        app_cmd_en   = 1'b0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        if (rstn) begin
            case (state_reg)
                IDLE: begin
                    io_pop_valid = io_pop_ready && !head_is_wt && !head_is_rd;
                end
                WT_CMD: begin
                    app_cmd_en = 1'b1;
                    app_cmd    = APP_CMD_WRITE;
                end
                WT_DATA: begin
                    app_wdf_wren = io_pop_ready && !wt_abort;
                    io_pop_valid = app_wdf_rdy && !wt_abort;
                    app_wdf_end  = wt_last;
                    app_wdf_data = io_pop_wt_data;
                    app_wdf_mask = io_pop_wt_mask;
                end
                RD_CMD: begin
                    app_cmd_en   = 1'b1;
                    app_cmd      = APP_CMD_READ;
                    io_pop_valid = app_cmd_rdy;
                end
                default: begin
                end
            endcase
        end
    end

    assign app_addr         = addr_reg;
    assign app_burst_number = burst_reg;
    assign busy             = (state_reg != IDLE);
    assign rd_valid         = rd_valid_reg;
    assign rd_data          = rd_data_reg;
    assign rd_last          = rd_last_reg;
    assign err              = err_reg;

    // ------------------------------------------------------------------
    // Datapath: command latch, beat counters, read return, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_reg     <= '0;
            burst_reg    <= '0;
            beat_cnt_reg <= '0;
            rd_cnt_reg   <= '0;
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
            rd_data_reg  <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (idle_take_wt || idle_take_rd) begin
                addr_reg  <= io_pop_addr;
                burst_reg <= io_pop_burst_cnt;
            end

            if (idle_take_wt) begin
                beat_cnt_reg <= '0;
            end else if (wt_accept) begin
                beat_cnt_reg <= beat_cnt_reg + CNT_WIDTH'(1);
            end

            if (rd_cmd_accept) begin
                rd_cnt_reg <= '0;
            end else if (rd_beat) begin
                rd_cnt_reg <= rd_cnt_reg + CNT_WIDTH'(1);
            end

            // Read beats are forwarded one cycle late; stray beats are dropped.
            rd_valid_reg <= rd_beat;
            rd_last_reg  <= rd_beat && rd_last_beat;
            if (rd_beat) begin
                rd_data_reg <= app_rd_data;
            end

            if (wt_abort || stray_rd) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_cmd_exec.sv
// ---------------------------------------------------------------------------
// tb_ddr_cmd_exec
//
// Directed bench for ddr_cmd_exec. A small first-word-fall-through FIFO
// model feeds the io_pop_* inputs; handshakes are sampled mid-cycle and the
// head pointer advances just after each rising edge.
// ---------------------------------------------------------------------------
module tb_ddr_cmd_exec;

    localparam int AW = 27;
    localparam int BW = 6;
    localparam int DW = 128;
    localparam int MW = 16;

    logic          clk;
    logic          rstn;
    logic          io_pop_valid;
    logic          io_pop_ready;
    logic [1:0]    io_pop_cmd_type;
    logic [AW-1:0] io_pop_addr;
    logic [BW-1:0] io_pop_burst_cnt;
    logic [DW-1:0] io_pop_wt_data;
    logic [MW-1:0] io_pop_wt_mask;
    logic [2:0]    app_cmd;
    logic          app_cmd_en;
    logic [AW-1:0] app_addr;
    logic [BW-1:0] app_burst_number;
    logic          app_cmd_rdy;
    logic          app_wdf_wren;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          err;

    ddr_cmd_exec #(
        .ADDR_WIDTH(AW), .BRST_WIDTH(BW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .io_pop_valid      (io_pop_valid),
        .io_pop_ready      (io_pop_ready),
        .io_pop_cmd_type   (io_pop_cmd_type),
        .io_pop_addr       (io_pop_addr),
        .io_pop_burst_cnt  (io_pop_burst_cnt),
        .io_pop_wt_data    (io_pop_wt_data),
        .io_pop_wt_mask    (io_pop_wt_mask),
        .app_cmd           (app_cmd),
        .app_cmd_en        (app_cmd_en),
        .app_addr          (app_addr),
        .app_burst_number  (app_burst_number),
        .app_cmd_rdy       (app_cmd_rdy),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_mask      (app_wdf_mask),
        .app_wdf_end       (app_wdf_end),
        .app_wdf_rdy       (app_wdf_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data),
        .rd_last           (rd_last),
        .busy              (busy),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model
    logic [1:0]    f_type  [0:63];
    logic [AW-1:0] f_addr  [0:63];
    logic [BW-1:0] f_burst [0:63];
    logic [DW-1:0] f_data  [0:63];
    logic [MW-1:0] f_mask  [0:63];
    int head = 0;
    int tail = 0;

    assign io_pop_ready     = (head < tail);
    assign io_pop_cmd_type  = f_type[head & 63];
    assign io_pop_addr      = f_addr[head & 63];
    assign io_pop_burst_cnt = f_burst[head & 63];
    assign io_pop_wt_data   = f_data[head & 63];
    assign io_pop_wt_mask   = f_mask[head & 63];

    // Transaction monitor record
    int            ncmd, nbeat, npop;
    logic [2:0]    cmd_type_seen;
    logic [AW-1:0] cmd_addr_seen;
    logic [BW-1:0] cmd_burst_seen;
    logic [DW-1:0] wb_data [0:63];
    logic [MW-1:0] wb_mask [0:63];
    logic          wb_end  [0:63];

    int checks = 0;
    int errors = 0;

    localparam logic [DW-1:0] WBASE = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [DW-1:0] RBASE = 128'h5555aaaa00001111222233334444f000;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] t, input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
        f_type[tail & 63]  = t;
        f_addr[tail & 63]  = a;
        f_burst[tail & 63] = b;
        f_data[tail & 63]  = d;
        f_mask[tail & 63]  = m;
        tail++;
    endtask

    task automatic clear_mon();
        ncmd = 0; nbeat = 0; npop = 0;
        cmd_type_seen = '0; cmd_addr_seen = '0; cmd_burst_seen = '0;
    endtask

    // Sample handshakes mid-cycle, let one rising edge pass, then advance the
    // FIFO head just after the edge and return on the following falling edge.
    task automatic tick();
        logic pop;
        pop = io_pop_valid && io_pop_ready;
        if (app_cmd_en && app_cmd_rdy) begin
            ncmd++;
            cmd_type_seen  = app_cmd;
            cmd_addr_seen  = app_addr;
            cmd_burst_seen = app_burst_number;
        end
        if (app_wdf_wren && app_wdf_rdy && nbeat < 64) begin
            wb_data[nbeat] = app_wdf_data;
            wb_mask[nbeat] = app_wdf_mask;
            wb_end[nbeat]  = app_wdf_end;
            nbeat++;
        end
        @(posedge clk);
        #1;
        if (pop) begin
            head++;
            npop++;
        end
        @(negedge clk);
    endtask

    task automatic check_write(input string tn, input logic [AW-1:0] a);
        chk({tn, "_ncmd"}, DW'(ncmd), DW'(1));
        chk({tn, "_cmd_type"}, DW'(cmd_type_seen), DW'(0));
        chk({tn, "_cmd_addr"}, DW'(cmd_addr_seen), DW'(a));
        chk({tn, "_cmd_burst"}, DW'(cmd_burst_seen), DW'(7));
        chk({tn, "_nbeat"}, DW'(nbeat), DW'(8));
        chk({tn, "_npop"}, DW'(npop), DW'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_data%0d", tn, i), wb_data[i], WBASE + DW'(i));
            chk($sformatf("%s_mask%0d", tn, i), DW'(wb_mask[i]), DW'(i));
            chk($sformatf("%s_end%0d", tn, i), DW'(wb_end[i]), DW'(i == 7));
        end
    endtask

    initial begin
        rstn = 1'b0;
        app_cmd_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        app_rd_data = '0;
        app_rd_data_valid = 1'b0;
        clear_mon();

        // ---------------- reset: IDE at head must not be popped ----------
        push(2'd0, '0, '0, '0, '0);
        @(negedge clk); #1;
        chk("rst_pop_valid", DW'(io_pop_valid), DW'(0));
        chk("rst_cmd_en", DW'(app_cmd_en), DW'(0));
        chk("rst_wren", DW'(app_wdf_wren), DW'(0));
        chk("rst_rd_valid", DW'(rd_valid), DW'(0));
        chk("rst_rd_data", rd_data, '0);
        chk("rst_err", DW'(err), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        tick(); tick();
        chk("rst_npop", DW'(npop), DW'(0));
        rstn = 1'b1; #1;
        chk("post_rst_pop_ide", DW'(io_pop_valid), DW'(1));
        tick();
        chk("post_rst_npop", DW'(npop), DW'(1));
        $display("step reset: IDE discarded after release");

        // ---------------- T1: 8-beat write, memory always ready ----------
        clear_mon();
        app_cmd_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int i = 0; i < 8; i++) push(2'd2, 27'h100, 6'd7, WBASE + DW'(i), MW'(i));
        repeat (14) tick();
        check_write("t1", 27'h100);
        chk("t1_busy", DW'(busy), DW'(0));
        $display("step t1: write burst addr=100 beats=%0d pops=%0d", nbeat, npop);

        // ---------------- T2: same write, app_wdf_rdy toggling ------------
        clear_mon();
        for (int i = 0; i < 8; i++) push(2'd2, 27'h200, 6'd7, WBASE + DW'(i), MW'(i));
        for (int c = 0; c < 30; c++) begin
            app_wdf_rdy = c[0];
            #1;
            tick();
        end
        app_wdf_rdy = 1'b1;
        check_write("t2", 27'h200);
        $display("step t2: throttled write beats=%0d pops=%0d", nbeat, npop);

        // ---------------- T3: read, cmd_rdy delayed 3 cycles --------------
        clear_mon();
        app_cmd_rdy = 1'b0;
        push(2'd3, 27'h1, 6'd7, '0, '0);
        #1;
        chk("t3_idle_cmd_en", DW'(app_cmd_en), DW'(0));
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t3_hold_cmd_en%0d", k), DW'(app_cmd_en), DW'(1));
            chk($sformatf("t3_hold_cmd%0d", k), DW'(app_cmd), DW'(1));
            chk($sformatf("t3_hold_pop%0d", k), DW'(io_pop_valid), DW'(0));
            tick();
        end
        app_cmd_rdy = 1'b1; #1;
        chk("t3_pop_with_rdy", DW'(io_pop_valid), DW'(1));
        chk("t3_addr", DW'(app_addr), DW'(1));
        chk("t3_burst", DW'(app_burst_number), DW'(7));
        tick();
        app_cmd_rdy = 1'b0;
        chk("t3_npop", DW'(npop), DW'(1));
        for (int i = 0; i < 8; i++) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = RBASE + DW'(i);
            #1;
            if (i > 0) begin
                chk($sformatf("t3_rd_valid%0d", i - 1), DW'(rd_valid), DW'(1));
                chk($sformatf("t3_rd_data%0d", i - 1), rd_data, RBASE + DW'(i - 1));
                chk($sformatf("t3_rd_last%0d", i - 1), DW'(rd_last), DW'(0));
            end
            tick();
        end
        app_rd_data_valid = 1'b0; #1;
        chk("t3_rd_valid7", DW'(rd_valid), DW'(1));
        chk("t3_rd_data7", rd_data, RBASE + DW'(7));
        chk("t3_rd_last7", DW'(rd_last), DW'(1));
        chk("t3_busy_end", DW'(busy), DW'(0));
        tick(); #1;
        chk("t3_rd_valid_off", DW'(rd_valid), DW'(0));
        $display("step t3: read addr=1 burst=7 returned");

        // ---------------- T4: IDE, CMD discarded, then RD ---------------
        clear_mon();
        app_cmd_rdy = 1'b1;
        push(2'd0, '0, '0, '0, '0);
        push(2'd1, '0, '0, '0, '0);
        push(2'd3, 27'h5, 6'd0, '0, '0);
        #1;
        chk("t4_pop_ide", DW'(io_pop_valid), DW'(1));
        chk("t4_cmd_en_ide", DW'(app_cmd_en), DW'(0));
        tick(); #1;
        chk("t4_pop_cmd", DW'(io_pop_valid), DW'(1));
        chk("t4_cmd_en_cmd", DW'(app_cmd_en), DW'(0));
        tick(); #1;
        chk("t4_pop_rd_idle", DW'(io_pop_valid), DW'(0));
        chk("t4_cmd_en_idle", DW'(app_cmd_en), DW'(0));
        tick(); #1;
        chk("t4_rd_cmd_en", DW'(app_cmd_en), DW'(1));
        chk("t4_rd_addr", DW'(app_addr), DW'(5));
        chk("t4_rd_pop", DW'(io_pop_valid), DW'(1));
        tick();
        chk("t4_npop", DW'(npop), DW'(3));
        app_cmd_rdy = 1'b0;
        app_rd_data_valid = 1'b1; app_rd_data = 128'hbeef; #1;
        tick();
        app_rd_data_valid = 1'b0; #1;
        chk("t4_rd_data", rd_data, 128'hbeef);
        chk("t4_rd_last", DW'(rd_last), DW'(1));
        chk("t4_busy_end", DW'(busy), DW'(0));
        tick();
        $display("step t4: IDE/CMD discarded, RD burst=0 done");

        // ---------------- T5: RD head after 3 write beats ---------------
        clear_mon();
        app_cmd_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int i = 0; i < 3; i++) push(2'd2, 27'h40, 6'd7, WBASE + DW'(i), MW'(i));
        push(2'd3, 27'h9, 6'd0, '0, '0);
        repeat (5) begin #1; tick(); end
        #1;
        chk("t5_abort_wren", DW'(app_wdf_wren), DW'(0));
        chk("t5_abort_pop", DW'(io_pop_valid), DW'(0));
        chk("t5_err_before", DW'(err), DW'(0));
        tick(); #1;
        chk("t5_err", DW'(err), DW'(1));
        chk("t5_busy", DW'(busy), DW'(0));
        chk("t5_npop", DW'(npop), DW'(3));
        chk("t5_nbeat", DW'(nbeat), DW'(3));
        tick(); #1;
        chk("t5_rd_cmd_en", DW'(app_cmd_en), DW'(1));
        chk("t5_rd_addr", DW'(app_addr), DW'(9));
        tick();
        app_rd_data_valid = 1'b1; app_rd_data = 128'hdead; #1;
        tick();
        app_rd_data_valid = 1'b0; #1;
        chk("t5_rd_last", DW'(rd_last), DW'(1));
        chk("t5_err_sticky", DW'(err), DW'(1));
        tick();
        $display("step t5: write aborted by RD head, err set");

        // ---------------- T6: reset during beat 4 of a write ------------
        clear_mon();
        for (int i = 0; i < 8; i++) push(2'd2, 27'h80, 6'd7, WBASE + DW'(i), MW'(i));
        repeat (5) tick();
        #1;
        chk("t6_beat4_wren", DW'(app_wdf_wren), DW'(1));
        chk("t6_nbeat3", DW'(nbeat), DW'(3));
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_pop", DW'(io_pop_valid), DW'(0));
        chk("t6_rst_wren", DW'(app_wdf_wren), DW'(0));
        chk("t6_rst_end", DW'(app_wdf_end), DW'(0));
        chk("t6_rst_wdata", app_wdf_data, '0);
        chk("t6_rst_cmd_en", DW'(app_cmd_en), DW'(0));
        chk("t6_rst_addr", DW'(app_addr), DW'(0));
        chk("t6_rst_rd_data", rd_data, '0);
        chk("t6_rst_rd_last", DW'(rd_last), DW'(0));
        chk("t6_rst_err", DW'(err), DW'(0));
        chk("t6_rst_busy", DW'(busy), DW'(0));
        tick(); tick();
        chk("t6_rst_npop", DW'(npop), DW'(3));
        rstn = 1'b1; #1;
        chk("t6_rel_pop", DW'(io_pop_valid), DW'(0));
        chk("t6_rel_busy", DW'(busy), DW'(0));
        $display("step t6: reset mid-burst, pops=%0d", npop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
